// File: rtl/e203_itcm_loader.sv
// e203_itcm_loader: byte-stream <-> ITCM SRAM port master.
// Loads a byte stream into ITCM as masked 64-bit writes, or dumps an ITCM
// region back out as a byte stream. All outputs are decoded from the state
// register and datapath flops, so handshake inputs never reach an output
// combinationally.
module e203_itcm_loader #(
    parameter int AW = 13,
    parameter int DW = 64,
    parameter int MW = 8,
    parameter int LW = AW + 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_load,
    input  logic          start_dump,
    input  logic [AW-1:0] start_addr,
    input  logic [LW-1:0] len,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_data,
    output logic          ram_cs,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [MW-1:0] ram_wem,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LD_COLLECT = 3'd1,
        LD_WRITE   = 3'd2,
        DP_READ    = 3'd3,
        DP_WAIT    = 3'd4,
        DP_SEND    = 3'd5,
        DONE       = 3'd6
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q,  addr_d;   // current RAM word address
    logic [LW-1:0] cnt_q,   cnt_d;    // bytes still to move
    logic [2:0]    lane_q,  lane_d;   // byte lane within the current word
    logic [DW-1:0] word_q,  word_d;   // assembled (load) or captured (dump) word
    logic [MW-1:0] wem_q,   wem_d;    // lanes filled so far on a load

    // State and datapath registers; reset clears everything so outputs read zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            lane_q  <= '0;
            word_q  <= '0;
            wem_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            lane_q  <= lane_d;
            word_q  <= word_d;
            wem_q   <= wem_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        lane_d  = lane_q;
        word_d  = word_q;
        wem_d   = wem_q;
        case (state_q)
            IDLE: begin
                if (start_load || start_dump) begin
                    addr_d = start_addr;
                    cnt_d  = len;
                    lane_d = '0;
                    word_d = '0;
                    wem_d  = '0;
                    // A zero-length request of either kind parks for one busy
                    // cycle in LD_COLLECT (in_ready stays low because cnt is 0)
                    // and then completes, so it never touches the RAM.
                    if (len == '0 || start_load) state_d = LD_COLLECT;
                    else                         state_d = DP_READ;
                end
            end
            LD_COLLECT: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else if (in_valid) begin
                    word_d[{lane_q, 3'b000} +: 8] = in_data;
                    wem_d[lane_q] = 1'b1;
                    cnt_d  = cnt_q - LW'(1);
                    lane_d = lane_q + 3'd1;
                    if (lane_q == 3'd7 || cnt_q == LW'(1)) state_d = LD_WRITE;
                end
            end
            LD_WRITE: begin
                // Write happens this cycle; prepare the next word.
                addr_d  = addr_q + AW'(1);
                lane_d  = '0;
                word_d  = '0;
                wem_d   = '0;
                state_d = (cnt_q != '0) ? LD_COLLECT : DONE;
            end
            DP_READ: begin
                state_d = DP_WAIT;
            end
            DP_WAIT: begin
                word_d  = ram_dout;
                lane_d  = '0;
                state_d = DP_SEND;
            end
            DP_SEND: begin
                if (out_ready) begin
                    cnt_d  = cnt_q - LW'(1);
                    lane_d = lane_q + 3'd1;
                    if (lane_q == 3'd7) addr_d = addr_q + AW'(1);
                    if (cnt_q == LW'(1))     state_d = DONE;
                    else if (lane_q == 3'd7) state_d = DP_READ;
                end
            end
            DONE: begin
                state_d = IDLE;
                addr_d  = '0;
                cnt_d   = '0;
                lane_d  = '0;
                word_d  = '0;
                wem_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from state and registers only; idle values are zero.
    always_comb begin
        in_ready  = (state_q == LD_COLLECT) && (cnt_q != '0);
        ram_cs    = (state_q == LD_WRITE) || (state_q == DP_READ);
        ram_we    = (state_q == LD_WRITE);
        ram_addr  = ram_cs ? addr_q : '0;
        ram_wem   = ram_we ? wem_q : '0;
        ram_din   = ram_we ? word_q : '0;
        out_valid = (state_q == DP_SEND);
        out_data  = out_valid ? word_q[{lane_q, 3'b000} +: 8] : 8'h00;
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
    end

endmodule

// File: tb/tb_e203_itcm_loader.sv
// Directed bench for e203_itcm_loader with a behavioural ITCM model.
module tb_e203_itcm_loader;

    localparam int AW = 13;
    localparam int DW = 64;
    localparam int MW = 8;
    localparam int LW = AW + 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_load = 1'b0, start_dump = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [LW-1:0] len = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    in_data = 8'h00;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [7:0]    out_data;
    logic          ram_cs, ram_we;
    logic [AW-1:0] ram_addr;
    logic [MW-1:0] ram_wem;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout = '0;
    logic          busy, done;

    int checks = 0;
    int errors = 0;

    e203_itcm_loader #(.AW(AW), .DW(DW), .MW(MW), .LW(LW)) dut (
        .clk(clk), .rst(rst),
        .start_load(start_load), .start_dump(start_dump),
        .start_addr(start_addr), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wem(ram_wem), .ram_din(ram_din), .ram_dout(ram_dout),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // ITCM model: masked write, read data registered one cycle after cs.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) begin
                for (int b = 0; b < 8; b++)
                    if (ram_wem[b]) mem[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
            end else begin
                ram_dout <= mem[ram_addr];
            end
        end
    end

    // Port monitor sampled mid-cycle.
    logic [AW-1:0] wr_addr[$];
    logic [MW-1:0] wr_wem[$];
    logic [DW-1:0] wr_din[$];
    int            wr_cyc[$];
    int            rd_cnt = 0, done_cnt = 0, done_cyc = 0, ir_bad = 0, cyc = 0;
    always @(negedge clk) begin
        if (ram_cs && ram_we) begin
            wr_addr.push_back(ram_addr);
            wr_wem.push_back(ram_wem);
            wr_din.push_back(ram_din);
            wr_cyc.push_back(cyc);
        end
        if (ram_cs && !ram_we) rd_cnt++;
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (ram_cs && in_ready) ir_bad++;
        cyc++;
    end

    task automatic clear_log();
        wr_addr.delete(); wr_wem.delete(); wr_din.delete(); wr_cyc.delete();
        rd_cnt = 0; done_cnt = 0; ir_bad = 0;
    endtask

    // Pulse a start for one cycle; returns on the negedge after acceptance.
    task automatic start_op(input logic ld, input logic dp, input logic [AW-1:0] a,
                            input logic [LW-1:0] n);
        start_load = ld; start_dump = dp; start_addr = a; len = n;
        @(negedge clk);
        start_load = 1'b0; start_dump = 1'b0;
    endtask

    // Push n bytes base, base+step, ... honoring in_ready.
    task automatic feed(input logic [7:0] base, input logic [7:0] step, input int n);
        int to;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = base + 8'(i) * step;
            to = 0;
            while (!in_ready && to < 50) begin @(negedge clk); to++; end
            if (to >= 50) begin
                checks++; errors++;
                $display("FAIL feed_timeout: byte %0d not accepted within 50 cycles", i);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        int to;
        to = 0;
        while (!done && to < 60) begin @(negedge clk); to++; end
        ok = done;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if ({in_ready, out_valid, ram_cs, ram_we, busy, done} !== 6'b0) begin errors++;
            $display("FAIL reset_ctrl: got %b want 000000", {in_ready, out_valid, ram_cs, ram_we, busy, done}); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h want 00", out_data); end
        checks++; if (ram_addr !== '0) begin errors++; $display("FAIL reset_ram_addr: got %h want 0", ram_addr); end
        checks++; if (ram_wem !== '0) begin errors++; $display("FAIL reset_ram_wem: got %h want 0", ram_wem); end
        checks++; if (ram_din !== '0) begin errors++; $display("FAIL reset_ram_din: got %h want 0", ram_din); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_load_one_word();
        bit ok;
        clear_log();
        start_op(1'b1, 1'b0, 13'd5, 16'd8);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ld8_busy_rise: got %b want 1", busy); end
        feed(8'h11, 8'h11, 8);
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL ld8_done_timeout: done not seen"); end
        checks++; if (wr_addr.size() != 1) begin errors++; $display("FAIL ld8_write_count: got %0d want 1", wr_addr.size()); end
        if (wr_addr.size() >= 1) begin
            checks++; if (wr_addr[0] !== 13'd5) begin errors++; $display("FAIL ld8_addr: got %0d want 5", wr_addr[0]); end
            checks++; if (wr_wem[0] !== 8'hFF) begin errors++; $display("FAIL ld8_wem: got %h want ff", wr_wem[0]); end
            checks++; if (wr_din[0] !== 64'h8877665544332211) begin errors++;
                $display("FAIL ld8_din: got %h want 8877665544332211", wr_din[0]); end
            checks++; if (done_cyc != wr_cyc[0] + 1) begin errors++;
                $display("FAIL ld8_done_timing: done at %0d want %0d", done_cyc, wr_cyc[0] + 1); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ld8_busy_fall: got %b want 0", busy); end
    endtask

    task automatic test_load_partial();
        bit ok;
        clear_log();
        start_op(1'b1, 1'b0, 13'd0, 16'd11);
        feed(8'h01, 8'h01, 11);
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL ld11_done_timeout: done not seen"); end
        checks++; if (wr_addr.size() != 2) begin errors++; $display("FAIL ld11_write_count: got %0d want 2", wr_addr.size()); end
        if (wr_addr.size() >= 2) begin
            checks++; if ({wr_addr[0], wr_wem[0]} !== {13'd0, 8'hFF}) begin errors++;
                $display("FAIL ld11_w0: got addr %0d wem %h want addr 0 wem ff", wr_addr[0], wr_wem[0]); end
            checks++; if (wr_din[0] !== 64'h0807060504030201) begin errors++;
                $display("FAIL ld11_w0_din: got %h want 0807060504030201", wr_din[0]); end
            checks++; if ({wr_addr[1], wr_wem[1]} !== {13'd1, 8'h07}) begin errors++;
                $display("FAIL ld11_w1: got addr %0d wem %h want addr 1 wem 07", wr_addr[1], wr_wem[1]); end
            checks++; if (wr_din[1] !== 64'h00000000000B0A09) begin errors++;
                $display("FAIL ld11_w1_din: got %h want 00000000000b0a09", wr_din[1]); end
        end
        checks++; if (ir_bad != 0) begin errors++; $display("FAIL ld11_in_ready_in_write: got %0d cycles want 0", ir_bad); end
    endtask

    task automatic test_dump_stalls();
        logic [31:0] pat;
        logic [7:0]  got[$];
        logic [7:0]  held;
        bit          hold;
        int          k, bad_stall, bad_data;
        pat = 32'hB5A3_6C9D;
        hold = 1'b0; held = 8'h00; k = 0; bad_stall = 0; bad_data = 0;
        clear_log();
        out_ready = 1'b0;
        start_op(1'b0, 1'b1, 13'd0, 16'd11);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dp_valid_read: got %b want 0", out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dp_valid_wait: got %b want 0", out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL dp_first_valid: got %b want 1", out_valid); end
        while (got.size() < 11 && k < 300) begin
            if (hold && (out_valid !== 1'b1 || out_data !== held)) bad_stall++;
            out_ready = pat[k % 32];
            if (out_valid && out_ready) begin got.push_back(out_data); hold = 1'b0; end
            else if (out_valid) begin hold = 1'b1; held = out_data; end
            else hold = 1'b0;
            @(negedge clk);
            k++;
        end
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (got.size() != 11) begin errors++; $display("FAIL dp_byte_count: got %0d want 11", got.size()); end
        for (int i = 0; i < got.size(); i++) if (got[i] !== 8'(i + 1)) bad_data++;
        checks++; if (bad_data != 0) begin errors++; $display("FAIL dp_data: got %0d wrong bytes want 0", bad_data); end
        checks++; if (bad_stall != 0) begin errors++; $display("FAIL dp_stall_hold: got %0d violations want 0", bad_stall); end
        checks++; if (rd_cnt != 2) begin errors++; $display("FAIL dp_read_count: got %0d want 2", rd_cnt); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL dp_done_count: got %0d want 1", done_cnt); end
    endtask

    task automatic test_zero_len();
        clear_log();
        in_valid = 1'b1; in_data = 8'hEE;
        start_op(1'b1, 1'b0, 13'd7, 16'd0);
        checks++; if ({busy, done, in_ready} !== 3'b100) begin errors++;
            $display("FAIL len0_cycle1: got busy/done/in_ready %b want 100", {busy, done, in_ready}); end
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL len0_done: got %b want 1", done); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL len0_idle: got %b want 00", {busy, done}); end
        checks++; if (wr_addr.size() + rd_cnt != 0) begin errors++;
            $display("FAIL len0_ram_access: got %0d accesses want 0", wr_addr.size() + rd_cnt); end
    endtask

    task automatic test_wrap_and_priority();
        bit ok;
        clear_log();
        start_op(1'b1, 1'b1, 13'h1FFF, 16'd16);
        feed(8'h21, 8'h01, 16);
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL wrap_done_timeout: done not seen"); end
        checks++; if (rd_cnt != 0) begin errors++; $display("FAIL prio_load_wins: got %0d reads want 0", rd_cnt); end
        checks++; if (wr_addr.size() != 2) begin errors++; $display("FAIL wrap_write_count: got %0d want 2", wr_addr.size()); end
        if (wr_addr.size() >= 2) begin
            checks++; if (wr_addr[0] !== 13'h1FFF) begin errors++; $display("FAIL wrap_addr0: got %h want 1fff", wr_addr[0]); end
            checks++; if (wr_addr[1] !== 13'h0000) begin errors++; $display("FAIL wrap_addr1: got %h want 0000", wr_addr[1]); end
            checks++; if ({wr_wem[0], wr_wem[1]} !== 16'hFFFF) begin errors++;
                $display("FAIL wrap_wem: got %h %h want ff ff", wr_wem[0], wr_wem[1]); end
            checks++; if (wr_din[1] !== 64'h302F2E2D2C2B2A29) begin errors++;
                $display("FAIL wrap_din1: got %h want 302f2e2d2c2b2a29", wr_din[1]); end
        end
    endtask

    task automatic test_reset_mid_load();
        bit ok;
        clear_log();
        start_op(1'b1, 1'b0, 13'd20, 16'd8);
        feed(8'hA0, 8'h01, 3);
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({busy, in_ready, ram_cs} !== 3'b000) begin errors++;
            $display("FAIL rstmid_outputs: got busy/in_ready/cs %b want 000", {busy, in_ready, ram_cs}); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (wr_addr.size() != 0) begin errors++; $display("FAIL rstmid_no_write: got %0d writes want 0", wr_addr.size()); end
        start_op(1'b1, 1'b0, 13'd20, 16'd8);
        feed(8'hA0, 8'h01, 8);
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_done_timeout: done not seen"); end
        checks++; if (wr_addr.size() != 1) begin errors++; $display("FAIL rstmid_fresh_count: got %0d want 1", wr_addr.size()); end
        if (wr_addr.size() >= 1) begin
            checks++; if ({wr_addr[0], wr_wem[0]} !== {13'd20, 8'hFF}) begin errors++;
                $display("FAIL rstmid_fresh_addr: got addr %0d wem %h want 20 ff", wr_addr[0], wr_wem[0]); end
            checks++; if (wr_din[0] !== 64'hA7A6A5A4A3A2A1A0) begin errors++;
                $display("FAIL rstmid_fresh_din: got %h want a7a6a5a4a3a2a1a0", wr_din[0]); end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_load_one_word();
        test_load_partial();
        test_dump_stalls();
        test_zero_len();
        test_wrap_and_priority();
        test_reset_mid_load();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
